// File: rtl/fwd_pkg.sv
// ============================================================================
//  Module   : fwd_pkg
//  Purpose  : Shared types, select codes and the youngest-producer picker for
//             the forwarding / hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    localparam int MAX_DEPTH = 6;
    localparam int MAX_AW    = 8;
    localparam int K_W       = 3;

    localparam int SEL_REGFILE  = 0;
    localparam int SEL_ALT      = 1;
    localparam int SEL_FWD_BASE = 2;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } fwd_state_t;

    typedef struct packed {
        logic [MAX_AW-1:0] rw;
        logic              regwrite;
        logic              memread;
        logic              valid;
    } fwd_entry_t;

    typedef struct packed {
        logic           hit;
        logic [K_W-1:0] k;
        logic           is_load;
    } fwd_pick_t;

    // Scans oldest to youngest so the lowest matching stage index is kept.
    function automatic fwd_pick_t fwd_pick(
        input logic [MAX_AW-1:0]              src,
        input fwd_entry_t [MAX_DEPTH-1:0]     entries,
        input int                             depth
    );
        fwd_pick_t res;
        res = '0;
        for (int k = MAX_DEPTH - 1; k >= 0; k--) begin
            if (k < depth && entries[k].valid && entries[k].regwrite &&
                entries[k].rw == src && src != '0) begin
                res.hit     = 1'b1;
                res.k       = K_W'(k);
                res.is_load = entries[k].memread;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_unit_match.sv
// ============================================================================
//  Module   : fwd_src_match
//  Purpose  : Priority matcher for one source register against the shadow
//             pipeline; yields the forward select and a load-use flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = 3
) (
    input  logic [REG_AW-1:0]           src,
    input  logic                        useSrc,
    input  fwd_entry_t [MAX_DEPTH-1:0]  entries,
    output logic [SEL_W-1:0]            fwdSel,
    output logic                        hazard,
    output logic [K_W-1:0]              hitStage
);

    logic [MAX_AW-1:0] w_srcExt;
    fwd_pick_t         w_pick;

    assign w_srcExt = MAX_AW'(src);
    assign w_pick   = fwd_pick(w_srcExt, entries, DEPTH);

    always_comb begin
        fwdSel   = SEL_W'(SEL_REGFILE);
        hazard   = 1'b0;
        hitStage = w_pick.k;
        if (useSrc && w_pick.hit) begin
            fwdSel = SEL_W'(SEL_FWD_BASE + int'(w_pick.k));
            hazard = w_pick.is_load && (int'(w_pick.k) < LOAD_LAT);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
//  Module   : fwd_hazard_unit
//  Purpose  : Operand forwarding and load-use stall control over a DEPTH-stage
//             shadow pipeline. Define FWD_PERF_CNT_EN for perf counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH + 2)
) (
    input  logic              CLK,
    input  logic              Resetb,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_shamt,
    input  logic              id_use_immed,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic [SEL_W-1:0]  alu_sel_a,
    output logic [SEL_W-1:0]  alu_sel_b,
    output logic [SEL_W-1:0]  st_sel,
    output logic              stall,
    output logic              bubble
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       fwd_count,
    output logic              ovf
`endif
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    fwd_entry_t                 r_shadow [DEPTH];
    fwd_entry_t [MAX_DEPTH-1:0] w_entries;
    fwd_entry_t                 w_entryIn;

    fwd_state_t                 r_state;
    fwd_state_t                 w_stateNext;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cntNext;
    logic [CNT_W-1:0]           w_cntDec;
    logic [CNT_W-1:0]           w_waitM1;

    logic [SEL_W-1:0]           w_selA, w_selB, w_selSt;
    logic                       w_hazA, w_hazB, w_hazSt;
    logic [K_W-1:0]             w_kA, w_kB, w_kSt;
    logic [K_W-1:0]             w_minK;
    logic                       w_hazard;
    logic                       w_stall;
    logic                       w_blockSel;

    always_comb begin
        w_entries = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_entries[k] = r_shadow[k];
        end
    end

    always_comb begin
        w_entryIn = '0;
        if (id_valid && !w_stall && !flush) begin
            w_entryIn.rw       = MAX_AW'(id_rw);
            w_entryIn.regwrite = id_regwrite;
            w_entryIn.memread  = id_memread;
            w_entryIn.valid    = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_shadow[0] <= w_entryIn;
            for (int k = 1; k < DEPTH; k++) begin
                r_shadow[k] <= r_shadow[k-1];
            end
        end
    end

    fwd_src_match #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) u_matchA (
        .src      (id_rs),
        .useSrc   (id_valid & id_use_rs),
        .entries  (w_entries),
        .fwdSel   (w_selA),
        .hazard   (w_hazA),
        .hitStage (w_kA)
    );

    fwd_src_match #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) u_matchB (
        .src      (id_rt),
        .useSrc   (id_valid & id_use_rt),
        .entries  (w_entries),
        .fwdSel   (w_selB),
        .hazard   (w_hazB),
        .hitStage (w_kB)
    );

    fwd_src_match #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) u_matchSt (
        .src      (id_rt),
        .useSrc   (id_valid & id_use_rt),
        .entries  (w_entries),
        .fwdSel   (w_selSt),
        .hazard   (w_hazSt),
        .hitStage (w_kSt)
    );

    // The youngest hazarded load sets the longest wait.
    always_comb begin
        w_minK = K_W'(MAX_DEPTH - 1);
        if (w_hazA  && w_kA  < w_minK) w_minK = w_kA;
        if (w_hazB  && w_kB  < w_minK) w_minK = w_kB;
        if (w_hazSt && w_kSt < w_minK) w_minK = w_kSt;
    end

    assign w_hazard = w_hazA | w_hazB | w_hazSt;
    assign w_waitM1 = CNT_W'(LOAD_LAT - 1 - int'(w_minK));
    assign w_cntDec = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : '0;

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_stall     = 1'b0;
        if (flush) begin
            w_stateNext = RUN;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hazard) begin
                        w_stall   = 1'b1;
                        w_cntNext = w_waitM1;
                        if (w_waitM1 != '0) w_stateNext = STALL;
                    end
                end
                STALL: begin
                    w_stall   = 1'b1;
                    w_cntNext = (w_hazard && w_waitM1 > w_cntDec) ? w_waitM1 : w_cntDec;
                    if (w_cntNext == '0) w_stateNext = RUN;
                end
                default: begin
                    w_stateNext = RUN;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    assign stall      = w_stall;
    assign bubble     = w_stall;
    assign w_blockSel = w_hazard | w_stall | !id_valid;

    always_comb begin
        alu_sel_a = SEL_W'(SEL_REGFILE);
        alu_sel_b = SEL_W'(SEL_REGFILE);
        st_sel    = SEL_W'(SEL_REGFILE);
        if (!w_blockSel) begin
            alu_sel_a = id_use_shamt ? SEL_W'(SEL_ALT) : w_selA;
            alu_sel_b = id_use_immed ? SEL_W'(SEL_ALT) : w_selB;
            st_sel    = w_selSt;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic w_anyFwd;

    assign w_anyFwd = (alu_sel_a >= SEL_W'(SEL_FWD_BASE)) ||
                      (alu_sel_b >= SEL_W'(SEL_FWD_BASE)) ||
                      (st_sel    >= SEL_W'(SEL_FWD_BASE));

    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            stall_cycles <= '0;
            fwd_count    <= '0;
            ovf          <= 1'b0;
        end else begin
            if (w_stall) begin
                if (&stall_cycles) ovf <= 1'b1;
                else               stall_cycles <= stall_cycles + 32'd1;
            end
            if (w_anyFwd) begin
                if (&fwd_count) ovf <= 1'b1;
                else            fwd_count <= fwd_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
//  Module   : tb_fwd_hazard_unit
//  Purpose  : Directed vectors plus hand sequences for fwd_hazard_unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

    localparam int DEPTH    = 3;
    localparam int REG_AW   = 5;
    localparam int LOAD_LAT = 2;
    localparam int SEL_W    = 3;

    logic              CLK;
    logic              Resetb;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_rw;
    logic              id_use_shamt, id_use_immed, id_use_rs, id_use_rt;
    logic              id_regwrite, id_memread, flush;
    logic [SEL_W-1:0]  alu_sel_a, alu_sel_b, st_sel;
    logic              stall, bubble;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]       stall_cycles, fwd_count;
    logic              ovf;
`endif

    int nErr    = 0;
    int nChecks = 0;

    fwd_hazard_unit #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) dut (
        .CLK          (CLK),
        .Resetb       (Resetb),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_shamt (id_use_shamt),
        .id_use_immed (id_use_immed),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rw        (id_rw),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .flush        (flush),
        .alu_sel_a    (alu_sel_a),
        .alu_sel_b    (alu_sel_b),
        .st_sel       (st_sel),
        .stall        (stall),
        .bubble       (bubble)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .fwd_count    (fwd_count),
        .ovf          (ovf)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int pRw; bit pWr; bit pLd; int gap;
        bit cValid; int rs; int rt; bit uRs; bit uRt; bit sh; bit im;
        int expA; int expB; int expSt; bit expStall;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(input int pRw, input bit pWr, input bit pLd, input int gap,
                                input bit cValid, input int rs, input int rt,
                                input bit uRs, input bit uRt, input bit sh, input bit im,
                                input int expA, input int expB, input int expSt,
                                input bit expStall);
        vec_t v;
        v.pRw = pRw; v.pWr = pWr; v.pLd = pLd; v.gap = gap;
        v.cValid = cValid; v.rs = rs; v.rt = rt; v.uRs = uRs; v.uRt = uRt;
        v.sh = sh; v.im = im;
        v.expA = expA; v.expB = expB; v.expSt = expSt; v.expStall = expStall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setId(input bit v, input int rs, input int rt, input bit uRs, input bit uRt,
                         input bit sh, input bit im, input int rw, input bit wr, input bit ld);
        id_valid     = v;
        id_rs        = REG_AW'(rs);
        id_rt        = REG_AW'(rt);
        id_use_rs    = uRs;
        id_use_rt    = uRt;
        id_use_shamt = sh;
        id_use_immed = im;
        id_rw        = REG_AW'(rw);
        id_regwrite  = wr;
        id_memread   = ld;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        idle();
        repeat (6) tick();
    endtask

    task automatic chkSels(input string tag, input int a, input int b, input int s);
        chk({tag, ".sel_a"}, 32'(alu_sel_a), a);
        chk({tag, ".sel_b"}, 32'(alu_sel_b), b);
        chk({tag, ".st_sel"}, 32'(st_sel), s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 pRw wr ld gap  v rs rt uRs uRt sh im   A  B St stall
        vecs[0]  = mk(3, 1, 0, 0,  1, 3, 5, 1, 1, 0, 0,  2, 0, 0, 0);
        vecs[1]  = mk(3, 1, 0, 1,  1, 3, 5, 1, 1, 0, 0,  3, 0, 0, 0);
        vecs[2]  = mk(3, 1, 0, 2,  1, 3, 5, 1, 1, 0, 0,  4, 0, 0, 0);
        vecs[3]  = mk(3, 1, 0, 3,  1, 3, 5, 1, 1, 0, 0,  0, 0, 0, 0);
        vecs[4]  = mk(3, 1, 0, 0,  1, 1, 3, 1, 1, 0, 0,  0, 2, 2, 0);
        vecs[5]  = mk(3, 1, 0, 0,  1, 1, 3, 1, 1, 0, 1,  0, 1, 2, 0);
        vecs[6]  = mk(3, 1, 0, 0,  1, 3, 5, 1, 1, 1, 0,  1, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0);
        vecs[8]  = mk(3, 0, 0, 0,  1, 3, 3, 1, 1, 0, 0,  0, 0, 0, 0);
        vecs[9]  = mk(3, 1, 0, 0,  0, 3, 3, 1, 1, 0, 0,  0, 0, 0, 0);
        vecs[10] = mk(7, 1, 1, 0,  1, 7, 5, 1, 1, 0, 0,  0, 0, 0, 1);
        vecs[11] = mk(7, 1, 1, 1,  1, 7, 5, 1, 1, 0, 0,  0, 0, 0, 1);
        vecs[12] = mk(7, 1, 1, 2,  1, 7, 5, 1, 1, 0, 0,  4, 0, 0, 0);
        vecs[13] = mk(7, 1, 1, 0,  1, 7, 5, 0, 1, 0, 0,  0, 0, 0, 0);
        vecs[14] = mk(7, 1, 1, 0,  1, 1, 7, 1, 1, 0, 1,  0, 0, 0, 1);

        // Reset state
        Resetb = 1'b0;
        flush  = 1'b0;
        idle();
        #3;
        chk("reset.stall", 32'(stall), 0);
        chk("reset.bubble", 32'(bubble), 0);
        chkSels("reset", 0, 0, 0);
`ifdef FWD_PERF_CNT_EN
        chk("reset.stall_cycles", stall_cycles, 0);
        chk("reset.ovf", 32'(ovf), 0);
`endif
        tick();
        tick();
        Resetb = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drain();
            setId(1, 0, 0, 0, 0, 0, 0, vecs[i].pRw, vecs[i].pWr, vecs[i].pLd);
            tick();
            idle();
            for (int g = 0; g < vecs[i].gap; g++) tick();
            setId(vecs[i].cValid, vecs[i].rs, vecs[i].rt, vecs[i].uRs, vecs[i].uRt,
                  vecs[i].sh, vecs[i].im, 9, 0, 0);
            #2;
            chkSels($sformatf("v%0d", i), vecs[i].expA, vecs[i].expB, vecs[i].expSt);
            chk($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].expStall));
            chk($sformatf("v%0d.bubble", i), 32'(bubble), 32'(vecs[i].expStall));
        end

        // Load-use: two stall cycles, then forward from stage 2
        drain();
        Resetb = 1'b0;
        tick();
        Resetb = 1'b1;
        setId(1, 0, 0, 0, 0, 0, 0, 7, 1, 1);
        tick();
        setId(1, 7, 1, 1, 1, 0, 0, 8, 1, 0);
        #2;
        chk("ld.c1.stall", 32'(stall), 1);
        chk("ld.c1.bubble", 32'(bubble), 1);
        chkSels("ld.c1", 0, 0, 0);
        tick();
        #2;
        chk("ld.c2.stall", 32'(stall), 1);
        tick();
        #2;
        chk("ld.c3.stall", 32'(stall), 0);
        chkSels("ld.c3", 4, 0, 0);
`ifdef FWD_PERF_CNT_EN
        chk("ld.stall_cycles", stall_cycles, 2);
        chk("ld.fwd_count0", fwd_count, 0);
`endif
        tick();
        setId(1, 8, 7, 1, 1, 0, 0, 0, 0, 0);
        #2;
        chkSels("ld.after", 2, 0, 0);
        chk("ld.after.stall", 32'(stall), 0);
`ifdef FWD_PERF_CNT_EN
        chk("ld.fwd_count1", fwd_count, 1);
`endif

        // Youngest producer wins over an older load of the same register
        drain();
        setId(1, 0, 0, 0, 0, 0, 0, 3, 1, 1);
        tick();
        setId(1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
        tick();
        setId(1, 3, 1, 1, 1, 0, 0, 0, 0, 0);
        #2;
        chk("young.sel_a", 32'(alu_sel_a), 2);
        chk("young.stall", 32'(stall), 0);

        // Flush in the second stall cycle
        drain();
        setId(1, 0, 0, 0, 0, 0, 0, 7, 1, 1);
        tick();
        setId(1, 7, 1, 1, 1, 0, 0, 8, 1, 0);
        #2;
        chk("flush.c1.stall", 32'(stall), 1);
        tick();
        #1;
        chk("flush.c2.stall", 32'(stall), 1);
        flush = 1'b1;
        #1;
        chk("flush.stall", 32'(stall), 0);
        chk("flush.bubble", 32'(bubble), 0);
        tick();
        flush = 1'b0;
        setId(1, 8, 7, 1, 1, 0, 0, 9, 0, 0);
        #2;
        chk("flush.next.stall", 32'(stall), 0);
        chkSels("flush.next", 0, 4, 4);

        // Reset in the middle of a stall
        drain();
        setId(1, 0, 0, 0, 0, 0, 0, 7, 1, 1);
        tick();
        setId(1, 7, 7, 1, 1, 0, 0, 8, 1, 0);
        #2;
        chk("rst.pre.stall", 32'(stall), 1);
        #1;
        Resetb = 1'b0;
        #1;
        chk("rst.stall", 32'(stall), 0);
        chk("rst.bubble", 32'(bubble), 0);
        chkSels("rst", 0, 0, 0);
        tick();
        tick();
        Resetb = 1'b1;
        #2;
        chk("rst.rel.stall", 32'(stall), 0);
        chkSels("rst.rel", 0, 0, 0);
`ifdef FWD_PERF_CNT_EN
        chk("rst.stall_cycles", stall_cycles, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
